// File: rtl/lockstep_pkg.sv
// Shared constants and types for the lockstep comparator.
package lockstep_pkg;

   localparam int unsigned DEPTH_DEFAULT = 4;
   localparam int unsigned CNT_W_DEFAULT = 16;
   localparam int unsigned DATA_W        = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StFail = 2'd2
   } state_e;

endpackage

// File: rtl/lockstep_fifo.sv
// Per-channel skew buffer; pointers carry an extra MSB so full and empty are distinguishable.
module lockstep_fifo
   import lockstep_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] head
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              do_push;
   logic              do_pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   // A pop in the same cycle frees the slot, so a push into a full buffer is accepted then.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/lockstep_checker.sv
// Compares two redundant sample streams through per-channel skew buffers and records
// the first divergence, saturating pair/mismatch counts and sticky error flags.
module lockstep_checker
   import lockstep_pkg::*;
#(
   parameter int unsigned DEPTH        = DEPTH_DEFAULT,
   parameter int unsigned CNT_W        = CNT_W_DEFAULT,
   parameter bit          STOP_ON_FAIL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_enable,
   input  logic [7:0]       a_data,
   input  logic             a_valid,
   input  logic [7:0]       b_data,
   input  logic             b_valid,
   output logic             cmp_valid,
   output logic             result,
   output logic             error,
   output logic             overflow,
   output logic [CNT_W-1:0] compare_count,
   output logic [CNT_W-1:0] mismatch_count,
   output logic [CNT_W-1:0] first_bad_idx,
   output logic [7:0]       first_bad_a,
   output logic [7:0]       first_bad_b,
   output logic [1:0]       state
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic       push_a, push_b;
   logic       a_full, a_empty, b_full, b_empty;
   logic [7:0] a_head, b_head;
   logic       do_cmp, mismatch, drop_a, drop_b;

   state_e           state_q, state_d;
   logic             cmp_valid_q, cmp_valid_d;
   logic             result_q, result_d;
   logic             error_q, error_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] compare_count_q, compare_count_d;
   logic [CNT_W-1:0] mismatch_count_q, mismatch_count_d;
   logic [CNT_W-1:0] first_bad_idx_q, first_bad_idx_d;
   logic [7:0]       first_bad_a_q, first_bad_a_d;
   logic [7:0]       first_bad_b_q, first_bad_b_d;

   assign push_a = clk_enable && a_valid;
   assign push_b = clk_enable && b_valid;

   // Heads only, never the incoming sample: a freshly pushed value waits one cycle.
   assign do_cmp   = clk_enable && !a_empty && !b_empty &&
                     !(STOP_ON_FAIL && (state_q == StFail));
   assign mismatch = (a_head != b_head);
   assign drop_a   = push_a && a_full && !do_cmp;
   assign drop_b   = push_b && b_full && !do_cmp;

   lockstep_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo_a (
      .clk   (clk),
      .reset (reset),
      .push  (push_a),
      .pop   (do_cmp),
      .wdata (a_data),
      .full  (a_full),
      .empty (a_empty),
      .head  (a_head)
   );

   lockstep_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo_b (
      .clk   (clk),
      .reset (reset),
      .push  (push_b),
      .pop   (do_cmp),
      .wdata (b_data),
      .full  (b_full),
      .empty (b_empty),
      .head  (b_head)
   );

   always_comb begin
      state_d          = state_q;
      cmp_valid_d      = cmp_valid_q;
      result_d         = result_q;
      error_d          = error_q;
      overflow_d       = overflow_q;
      compare_count_d  = compare_count_q;
      mismatch_count_d = mismatch_count_q;
      first_bad_idx_d  = first_bad_idx_q;
      first_bad_a_d    = first_bad_a_q;
      first_bad_b_d    = first_bad_b_q;

      if (clk_enable) begin
         cmp_valid_d = do_cmp;
         if (do_cmp) begin
            result_d = !mismatch;
            if (compare_count_q != '1) compare_count_d = compare_count_q + CNT_ONE;
            if (mismatch) begin
               error_d = 1'b1;
               if (mismatch_count_q != '1) mismatch_count_d = mismatch_count_q + CNT_ONE;
               // Saturating count never returns to zero, so zero marks "no mismatch yet".
               if (mismatch_count_q == '0) begin
                  first_bad_idx_d = compare_count_q;
                  first_bad_a_d   = a_head;
                  first_bad_b_d   = b_head;
               end
            end
         end
         if (drop_a || drop_b) begin
            overflow_d = 1'b1;
            error_d    = 1'b1;
         end

         unique case (state_q)
            StIdle:  if (push_a || push_b) state_d = StRun;
            StRun:   if ((do_cmp && mismatch) || drop_a || drop_b) state_d = StFail;
            StFail:  state_d = StFail;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= StIdle;
         cmp_valid_q      <= 1'b0;
         result_q         <= 1'b0;
         error_q          <= 1'b0;
         overflow_q       <= 1'b0;
         compare_count_q  <= '0;
         mismatch_count_q <= '0;
         first_bad_idx_q  <= '0;
         first_bad_a_q    <= '0;
         first_bad_b_q    <= '0;
      end else begin
         state_q          <= state_d;
         cmp_valid_q      <= cmp_valid_d;
         result_q         <= result_d;
         error_q          <= error_d;
         overflow_q       <= overflow_d;
         compare_count_q  <= compare_count_d;
         mismatch_count_q <= mismatch_count_d;
         first_bad_idx_q  <= first_bad_idx_d;
         first_bad_a_q    <= first_bad_a_d;
         first_bad_b_q    <= first_bad_b_d;
      end
   end

   assign cmp_valid      = cmp_valid_q;
   assign result         = result_q;
   assign error          = error_q;
   assign overflow       = overflow_q;
   assign compare_count  = compare_count_q;
   assign mismatch_count = mismatch_count_q;
   assign first_bad_idx  = first_bad_idx_q;
   assign first_bad_a    = first_bad_a_q;
   assign first_bad_b    = first_bad_b_q;
   assign state          = state_q;

endmodule

// File: tb/tb_lockstep_checker.sv
// Scoreboard bench for lockstep_checker: default, stop-on-fail and narrow-counter instances
// share one stimulus stream.
module tb_lockstep_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clk_enable = 1'b0;
   logic       a_valid = 1'b0;
   logic       b_valid = 1'b0;
   logic [7:0] a_data = '0;
   logic [7:0] b_data = '0;

   logic        cmp_valid, result, error, overflow;
   logic [15:0] compare_count, mismatch_count, first_bad_idx;
   logic [7:0]  first_bad_a, first_bad_b;
   logic [1:0]  state;

   logic        s_cmp_valid, s_result, s_error, s_overflow;
   logic [15:0] s_compare_count, s_mismatch_count, s_first_bad_idx;
   logic [7:0]  s_first_bad_a, s_first_bad_b;
   logic [1:0]  s_state;

   logic        t_cmp_valid, t_result, t_error, t_overflow;
   logic [3:0]  t_compare_count, t_mismatch_count, t_first_bad_idx;
   logic [7:0]  t_first_bad_a, t_first_bad_b;
   logic [1:0]  t_state;

   int   total = 0;
   int   bad = 0;
   int   n_cmp = 0;
   bit   sb_on = 1'b1;
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   bit   exp_q[$];

   always #5 clk = ~clk;

   lockstep_checker u_dut (
      .clk (clk), .reset (reset), .clk_enable (clk_enable),
      .a_data (a_data), .a_valid (a_valid), .b_data (b_data), .b_valid (b_valid),
      .cmp_valid (cmp_valid), .result (result), .error (error), .overflow (overflow),
      .compare_count (compare_count), .mismatch_count (mismatch_count),
      .first_bad_idx (first_bad_idx), .first_bad_a (first_bad_a),
      .first_bad_b (first_bad_b), .state (state)
   );

   lockstep_checker #(.STOP_ON_FAIL (1'b1)) u_dut_stop (
      .clk (clk), .reset (reset), .clk_enable (clk_enable),
      .a_data (a_data), .a_valid (a_valid), .b_data (b_data), .b_valid (b_valid),
      .cmp_valid (s_cmp_valid), .result (s_result), .error (s_error),
      .overflow (s_overflow), .compare_count (s_compare_count),
      .mismatch_count (s_mismatch_count), .first_bad_idx (s_first_bad_idx),
      .first_bad_a (s_first_bad_a), .first_bad_b (s_first_bad_b), .state (s_state)
   );

   lockstep_checker #(.CNT_W (4)) u_dut_sat (
      .clk (clk), .reset (reset), .clk_enable (clk_enable),
      .a_data (a_data), .a_valid (a_valid), .b_data (b_data), .b_valid (b_valid),
      .cmp_valid (t_cmp_valid), .result (t_result), .error (t_error),
      .overflow (t_overflow), .compare_count (t_compare_count),
      .mismatch_count (t_mismatch_count), .first_bad_idx (t_first_bad_idx),
      .first_bad_a (t_first_bad_a), .first_bad_b (t_first_bad_b), .state (t_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   // One enabled or disabled cycle; accepted samples are paired in order into expected results.
   task automatic drive(input bit en, input bit av, input logic [7:0] ad,
                        input bit bv, input logic [7:0] bd);
      logic [7:0] ha, hb;
      clk_enable = en;
      a_valid    = av;
      a_data     = ad;
      b_valid    = bv;
      b_data     = bd;
      if (en && av) qa.push_back(ad);
      if (en && bv) qb.push_back(bd);
      while (qa.size() > 0 && qb.size() > 0) begin
         ha = qa.pop_front();
         hb = qb.pop_front();
         exp_q.push_back(ha == hb);
      end
      @(posedge clk);
      #1;
      a_valid    = 1'b0;
      b_valid    = 1'b0;
      clk_enable = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   // Valids high and enable low during reset: reset must win regardless.
   task automatic do_reset();
      reset      = 1'b1;
      clk_enable = 1'b0;
      a_valid    = 1'b1;
      b_valid    = 1'b1;
      @(posedge clk);
      #1;
      reset      = 1'b0;
      a_valid    = 1'b0;
      b_valid    = 1'b0;
      clk_enable = 1'b1;
      qa.delete();
      qb.delete();
      exp_q.delete();
      n_cmp = 0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_cmp_valid"}, cmp_valid, 0);
      check({tag, "_result"}, result, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_overflow"}, overflow, 0);
      check({tag, "_compare_count"}, compare_count, 0);
      check({tag, "_mismatch_count"}, mismatch_count, 0);
      check({tag, "_first_bad_idx"}, first_bad_idx, 0);
      check({tag, "_first_bad_a"}, first_bad_a, 0);
      check({tag, "_first_bad_b"}, first_bad_b, 0);
      check({tag, "_state"}, state, 0);
   endtask

   always @(negedge clk) begin
      if (!reset && sb_on && cmp_valid) begin
         n_cmp++;
         if (exp_q.size() == 0) check("cmp_unexpected", cmp_valid, 0);
         else check("result", result, exp_q.pop_front());
      end
   end

   initial begin
      do_reset();
      check_zero("rst");

      // Equal streams in lockstep; first pair must not be compared in its push cycle.
      drive(1'b1, 1'b1, 8'h00, 1'b1, 8'h00);
      @(negedge clk);
      check("no_bypass", cmp_valid, 0);
      for (int i = 1; i < 10; i++) drive(1'b1, 1'b1, 8'(i), 1'b1, 8'(i));
      idle(3);
      check("eq_pulses", n_cmp, 10);
      check("eq_count", compare_count, 10);
      check("eq_result", result, 1);
      check("eq_error", error, 0);
      check("eq_state", state, 1);
      check("eq_drain", exp_q.size(), 0);

      // B lags by 3: buffer reaches full but every push coincides with a pop.
      do_reset();
      for (int t = 0; t < 13; t++)
         drive(1'b1, t < 10, 8'(t), t >= 3, 8'(t - 3));
      idle(3);
      check("skew3_overflow", overflow, 0);
      check("skew3_count", compare_count, 10);
      check("skew3_mismatch", mismatch_count, 0);
      check("skew3_drain", exp_q.size(), 0);

      // B lags by 5: A overflows; pairing becomes meaningless, so results are not scored.
      do_reset();
      sb_on = 1'b0;
      for (int t = 0; t < 15; t++)
         drive(1'b1, t < 10, 8'(t), t >= 5, 8'(t - 5));
      idle(3);
      check("skew5_overflow", overflow, 1);
      check("skew5_error", error, 1);
      check("skew5_state", state, 2);
      sb_on = 1'b1;

      // Sample 4 differs.
      do_reset();
      for (int i = 0; i < 10; i++)
         drive(1'b1, 1'b1, (i == 4) ? 8'h55 : 8'(i), 1'b1, (i == 4) ? 8'h5A : 8'(i));
      idle(3);
      check("mm_first_idx", first_bad_idx, 4);
      check("mm_first_a", first_bad_a, 8'h55);
      check("mm_first_b", first_bad_b, 8'h5A);
      check("mm_count", mismatch_count, 1);
      check("mm_compares", compare_count, 10);
      check("mm_state", state, 2);
      check("mm_error", error, 1);
      check("mm_result_last", result, 1);
      check("mm_drain", exp_q.size(), 0);
      check("stop_compares", s_compare_count, 5);
      check("stop_mismatch", s_mismatch_count, 1);
      check("stop_first_idx", s_first_bad_idx, 4);
      check("stop_state", s_state, 2);

      // Reset with two A samples buffered; stale entries must never be compared.
      drive(1'b1, 1'b1, 8'h11, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 8'h22, 1'b0, 8'h00);
      do_reset();
      check_zero("midrst");
      drive(1'b1, 1'b0, 8'h00, 1'b1, 8'h33);
      drive(1'b1, 1'b0, 8'h00, 1'b1, 8'h44);
      idle(3);
      check("midrst_no_cmp", n_cmp, 0);
      check("midrst_count0", compare_count, 0);
      drive(1'b1, 1'b1, 8'h33, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 8'h44, 1'b0, 8'h00);
      idle(3);
      check("midrst_fresh", compare_count, 2);
      check("midrst_drain", exp_q.size(), 0);

      // Enable low with valids high: nothing pushed, nothing counted.
      do_reset();
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'(i), 1'b1, 8'(i));
      idle(2);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB);
      check("en_hold", compare_count, 3);
      idle(3);
      check("en_no_push", compare_count, 3);
      check("en_no_mismatch", mismatch_count, 0);
      check("en_drain", exp_q.size(), 0);

      // 20 pairs: the 4-bit counter must stick at 15.
      do_reset();
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 8'(i), 1'b1, 8'(i));
      idle(3);
      check("sat_narrow", t_compare_count, 4'hF);
      check("sat_wide", compare_count, 20);
      check("sat_mismatch", t_mismatch_count, 0);
      check("sat_drain", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
